wall_depth_ctrl: RTL and testbench
==================================

# wall_depth_ctrl

Sequencer for one wall round. It moves the wall depth from 0 toward `MAX_WALL_DEPTH` at a frame-paced rate. When the wall reaches the player, it judges the round as pass or fail. `wall_depth_out` drives the wall-depth sprite and the wall renderer. `player_depth_in` comes from the depth-camera tracker, and `collision_in` comes from the silhouette/mask comparator.

## Interface
- `GOAL_DEPTH`, 60: centre of the scoring window, in depth units.
- `GOAL_DEPTH_DELTA`, 10: half-width of the scoring window; the window is inclusive at both ends.
- `MAX_WALL_DEPTH`, 75: last depth the wall can reach.
- `BASE_PERIOD`, 8: number of frames per one-unit depth step in round 0.
- `MIN_PERIOD`, 2: floor on the step period.
- `HOLD_FRAMES`, 60: number of frames the result is held before returning to idle.

Ports:
- `clk_in`  in  1  system/pixel clock.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `start_in`  in  1  one-cycle pulse that begins a round.
- `new_frame_in`  in  1  one-cycle pulse, once per video frame.
- `player_depth_in`  in  8  current player depth.
- `collision_in`  in  1  level signal; high when the player silhouette overlaps the wall.
- `wall_depth_out`  out  8  current wall depth.
- `wall_active_out`  out  1  high while the wall is moving.
- `busy_out`  out  1  high in any state other than IDLE.
- `result_valid_out`  out  1  one-cycle pulse on judgement.
- `pass_out`  out  1  verdict of the latest judgement; held until the next judgement.
- `round_out`  out  4  count of consecutive passed rounds.

## Operation
- States: IDLE, MOVING, JUDGE, HOLD.
- **IDLE:**
  - `start_in` → MOVING.
  - On entry to MOVING: `wall_depth_out`=0 and the frame counter=0.
- **MOVING:**
  - Each `new_frame_in` increments the frame counter.
  - When the counter reaches period−1: the counter clears and `wall_depth_out` increments by 1.
- **Judge trigger** (checked every cycle in MOVING, after any update):
  - `wall_depth_out` ≥ `player_depth_in`, or
  - `wall_depth_out` == `MAX_WALL_DEPTH`.
  - Either condition → JUDGE.
- **JUDGE** (one cycle):
  - Sample `collision_in` and `player_depth_in`.
  - pass = (`GOAL_DEPTH`−`GOAL_DEPTH_DELTA` ≤ `player_depth_in` ≤ `GOAL_DEPTH`+`GOAL_DEPTH_DELTA`) AND !`collision_in`.
  - Pulse `result_valid_out` and update `pass_out`.
  - On pass, `round_out` increments and saturates at 15. On fail, `round_out` clears.
  - Next state: HOLD.
- **HOLD:**
  - `wall_depth_out` is frozen.
  - Count `HOLD_FRAMES` occurrences of `new_frame_in`, then go to IDLE.
- **Period:** `BASE_PERIOD`, or the speed-up formula when enabled (see Configuration).
- **Arithmetic:**
  - Window bounds are computed at 9 bits signed, so `GOAL_DEPTH`<`GOAL_DEPTH_DELTA` cannot underflow.
  - The depth increment never exceeds `MAX_WALL_DEPTH`.
- **`start_in` outside IDLE** is ignored.
- **`start_in` and `new_frame_in` in the same cycle** (IDLE): the start is taken; that frame pulse does not count.
- **`player_depth_in` = 0 at start:** the first MOVING cycle triggers the judge (0 ≥ 0).

## Timing
- **Reset values:**
  - `wall_depth_out`=0, `wall_active_out`=0, `busy_out`=0.
  - `result_valid_out`=0, `pass_out`=0, `round_out`=0.
  - State=IDLE.
- **Reset mid-round:** all outputs and state clear immediately and asynchronously; no `result_valid_out` pulse is issued.
- All outputs are registered.
- `start_in` at edge N: MOVING from N+1, with `wall_active_out` and `busy_out` high from N+1.
- A depth step is visible one cycle after the qualifying `new_frame_in`.
- Trigger condition true at edge N:
  - JUDGE at N+1.
  - `result_valid_out`, `pass_out` and `round_out` valid at N+2.
  - `wall_active_out` low from N+1.
- `busy_out` falls the cycle after the `HOLD_FRAMES`-th frame pulse in HOLD.

## Configuration
- **`WALL_SPEEDUP_EN` defined:**
  - period = max(`MIN_PERIOD`, `BASE_PERIOD` − `round_out`).
  - The period is latched on entry to MOVING and is constant within a round.
- **`WALL_SPEEDUP_EN` undefined:**
  - period = `BASE_PERIOD` always.
  - `round_out` still counts.

## Structure
- **Package `hole_wall_pkg`:**
  - `wall_state_t` enum (IDLE, MOVING, JUDGE, HOLD).
  - Depth width constant (8).
  - Round width constant (4).
- **Sub-module `frame_step_timer`:**
  - Counts `new_frame_in` up to a runtime period input.
  - Emits a one-cycle step pulse.
  - Has a synchronous clear input.
  - Used for both the MOVING step timing and the HOLD timing.

## Test plan
- **Reset:** assert `rst_n_in` low mid-MOVING at depth 30 → all outputs return to 0 in the same cycle; no `result_valid_out` pulse.
- **Fixed pass:** `player_depth_in`=60, no collision, period 8 → `wall_depth_out` reaches 60 after 480 frame pulses; JUDGE follows; `pass_out`=1 and `round_out`=1.
- **Window edges:** player at 50 and at 70 → pass; player at 49 and at 71 → fail.
- **Collision:** player=60 with `collision_in`=1 at JUDGE → `pass_out`=0 and `round_out` clears to 0.
- **Player beyond max:** player=90 → wall stops at 75, JUDGE occurs, fail.
- **Speed-up** (`WALL_SPEEDUP_EN`): after 3 passes the step period is 5 frames; after 6 or more passes it is 2 frames. A `start_in` during HOLD is ignored.

Source files
------------

// File: rtl/hole_wall_pkg.sv
// Shared types and widths for the hole-in-the-wall round sequencer.
// Holds the state encoding and the speed-up period helper.
package hole_wall_pkg;

   localparam int DEPTH_W = 8;
   localparam int ROUND_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      MOVING,
      JUDGE,
      HOLD
   } wall_state_t;

   // Step period shrinks by one frame per consecutive pass, floored at min_p.
   function automatic logic [DEPTH_W-1:0] speed_period(
      input logic [ROUND_W-1:0] round,
      input int                 base,
      input int                 min_p
   );
      int p;
      p = base - int'(round);
      if (p < min_p) p = min_p;
      return DEPTH_W'(p);
   endfunction

endpackage

// File: rtl/wall_depth_ctrl_frame_step_timer.sv
// Frame-pulse divider: counts tick pulses and flags the one that completes
// a period. Shared by the wall movement and the result-hold timing.
module frame_step_timer
   import hole_wall_pkg::*;
#(
   parameter int W = DEPTH_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         tick,
   input  logic [W-1:0] period,
   output logic         step
);

   logic [W-1:0] count;
   logic         at_end;

   // >= keeps the counter from running past a period that shrinks mid-count.
   assign at_end = (count >= period - W'(1));

   // NOTE: step is combinational on purpose, so the owner can act on the same
   // edge that samples the completing tick instead of one cycle later.
   assign step = tick && at_end && !clear;

   // NOTE: sequential state is written only with non-blocking assignments, so
   // every register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (tick) begin
         count <= at_end ? '0 : count + W'(1);
      end
   end

endmodule

// File: rtl/wall_depth_ctrl.sv
// Wall round sequencer: advances the wall toward the player, judges the pose,
// then holds the verdict. Define WALL_SPEEDUP_EN to shorten the step period
// as the pass streak grows.
module wall_depth_ctrl
   import hole_wall_pkg::*;
#(
   parameter int GOAL_DEPTH       = 60,
   parameter int GOAL_DEPTH_DELTA = 10,
   parameter int MAX_WALL_DEPTH   = 75,
   parameter int BASE_PERIOD      = 8,
   parameter int MIN_PERIOD       = 2,
   parameter int HOLD_FRAMES      = 60
) (
   input  logic               clk_in,
   input  logic               rst_n_in,
   input  logic               start_in,
   input  logic               new_frame_in,
   input  logic [DEPTH_W-1:0] player_depth_in,
   input  logic               collision_in,
   output logic [DEPTH_W-1:0] wall_depth_out,
   output logic               wall_active_out,
   output logic               busy_out,
   output logic               result_valid_out,
   output logic               pass_out,
   output logic [ROUND_W-1:0] round_out
);

   localparam logic [DEPTH_W-1:0] MAX_DEPTH   = DEPTH_W'(MAX_WALL_DEPTH);
   localparam logic [DEPTH_W-1:0] HOLD_PERIOD = DEPTH_W'(HOLD_FRAMES);

   // Signed 9-bit bounds so a window reaching below zero stays meaningful.
   localparam logic signed [8:0] WIN_LO = 9'(GOAL_DEPTH - GOAL_DEPTH_DELTA);
   localparam logic signed [8:0] WIN_HI = 9'(GOAL_DEPTH + GOAL_DEPTH_DELTA);

   wall_state_t        state;
   logic [DEPTH_W-1:0] move_period;
   logic [DEPTH_W-1:0] timer_period;
   logic               timer_clear;
   logic               step;
   logic               trigger;
   logic               judge_pass;
   logic signed [8:0]  player_s;

`ifdef WALL_SPEEDUP_EN
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         move_period <= DEPTH_W'(BASE_PERIOD);
      end else if (state == IDLE && start_in) begin
         move_period <= speed_period(round_out, BASE_PERIOD, MIN_PERIOD);
      end
   end
`else
   assign move_period = DEPTH_W'(BASE_PERIOD);
`endif

   // The timer is held clear outside the counting states, so a frame pulse
   // coinciding with start or with the judgement cycle is never counted.
   assign timer_clear  = (state == IDLE) || (state == JUDGE);
   assign timer_period = (state == HOLD) ? HOLD_PERIOD : move_period;

   frame_step_timer #(.W(DEPTH_W)) u_timer (
      .clk    (clk_in),
      .rst_n  (rst_n_in),
      .clear  (timer_clear),
      .tick   (new_frame_in),
      .period (timer_period),
      .step   (step)
   );

   assign player_s   = signed'({1'b0, player_depth_in});
   assign trigger    = (wall_depth_out >= player_depth_in) || (wall_depth_out == MAX_DEPTH);
   assign judge_pass = (player_s >= WIN_LO) && (player_s <= WIN_HI) && !collision_in;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state            <= IDLE;
         wall_depth_out   <= '0;
         wall_active_out  <= 1'b0;
         busy_out         <= 1'b0;
         result_valid_out <= 1'b0;
         pass_out         <= 1'b0;
         round_out        <= '0;
      end else begin
         result_valid_out <= 1'b0;
         case (state)
            IDLE: begin
               if (start_in) begin
                  state           <= MOVING;
                  wall_depth_out  <= '0;
                  wall_active_out <= 1'b1;
                  busy_out        <= 1'b1;
               end
            end
            MOVING: begin
               // Trigger sees the already-updated depth, so it takes priority.
               if (trigger) begin
                  state           <= JUDGE;
                  wall_active_out <= 1'b0;
               end else if (step && wall_depth_out < MAX_DEPTH) begin
                  wall_depth_out <= wall_depth_out + DEPTH_W'(1);
               end
            end
            JUDGE: begin
               result_valid_out <= 1'b1;
               pass_out         <= judge_pass;
               if (judge_pass) begin
                  if (round_out != '1) round_out <= round_out + ROUND_W'(1);
               end else begin
                  round_out <= '0;
               end
               state <= HOLD;
            end
            HOLD: begin
               if (step) begin
                  state    <= IDLE;
                  busy_out <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wall_depth_ctrl.sv
// Directed bench for wall_depth_ctrl: table of full rounds, streak saturation
// and a mid-round asynchronous reset.
module tb_wall_depth_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       new_frame;
   logic [7:0] player_depth;
   logic       collision;
   logic [7:0] wall_depth;
   logic       wall_active;
   logic       busy;
   logic       result_valid;
   logic       pass;
   logic [3:0] round;

   int n_cmp = 0;
   int n_bad = 0;
   int cur_round = 0;

   always #5 clk = ~clk;

   wall_depth_ctrl dut (
      .clk_in           (clk),
      .rst_n_in         (rst_n),
      .start_in         (start),
      .new_frame_in     (new_frame),
      .player_depth_in  (player_depth),
      .collision_in     (collision),
      .wall_depth_out   (wall_depth),
      .wall_active_out  (wall_active),
      .busy_out         (busy),
      .result_valid_out (result_valid),
      .pass_out         (pass),
      .round_out        (round)
   );

   typedef struct {
      logic [7:0] player;
      logic       col;
      logic       exp_pass;
      logic [3:0] exp_round;
      logic [7:0] exp_depth;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int period_for(input int r);
`ifdef WALL_SPEEDUP_EN
      return (8 - r < 2) ? 2 : 8 - r;
`else
      return 8;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full round with new_frame held high every cycle, including the start cycle.
   task automatic run_round(input logic [7:0] p, input logic c, input logic exp_pass,
                            input logic [3:0] exp_round, input logic [7:0] exp_depth);
      int n;
      int per;
      per = period_for(cur_round);
      player_depth = p;
      collision    = c;
      start        = 1'b1;
      tick();
      start = 1'b0;
      check("start_active", wall_active, 1);
      check("start_busy", busy, 1);
      check("start_depth", wall_depth, 0);
      n = 0;
      while (result_valid !== 1'b1 && n < 2000) begin
         tick();
         n++;
      end
      check("result_seen", result_valid, 1);
      check("judge_latency", n, int'(exp_depth) * per + 2);
      check("pass", pass, exp_pass);
      check("round", round, exp_round);
      check("final_depth", wall_depth, exp_depth);
      check("judge_active", wall_active, 0);
      check("judge_busy", busy, 1);
      for (int k = 1; k < 60; k++) begin
         tick();
         if (k == 1)  check("valid_pulse", result_valid, 0);
         if (k == 30) start = 1'b1;
         if (k == 31) begin
            start = 1'b0;
            check("hold_start_ignored", wall_active, 0);
            check("hold_depth", wall_depth, exp_depth);
         end
         if (k == 59) check("hold_busy", busy, 1);
      end
      tick();
      check("hold_done_busy", busy, 0);
      check("pass_held", pass, exp_pass);
      check("round_held", round, exp_round);
      cur_round = exp_round;
   endtask

   initial begin
      int n;
      vecs[0] = '{8'd60, 1'b0, 1'b1, 4'd1, 8'd60};
      vecs[1] = '{8'd50, 1'b0, 1'b1, 4'd2, 8'd50};
      vecs[2] = '{8'd70, 1'b0, 1'b1, 4'd3, 8'd70};
      vecs[3] = '{8'd49, 1'b0, 1'b0, 4'd0, 8'd49};
      vecs[4] = '{8'd60, 1'b0, 1'b1, 4'd1, 8'd60};
      vecs[5] = '{8'd71, 1'b0, 1'b0, 4'd0, 8'd71};
      vecs[6] = '{8'd60, 1'b1, 1'b0, 4'd0, 8'd60};
      vecs[7] = '{8'd90, 1'b0, 1'b0, 4'd0, 8'd75};
      vecs[8] = '{8'd0,  1'b0, 1'b0, 4'd0, 8'd0};

      rst_n = 1'b0;
      start = 1'b0;
      new_frame = 1'b0;
      player_depth = 8'd0;
      collision = 1'b0;
      #12;
      check("rst_depth", wall_depth, 0);
      check("rst_active", wall_active, 0);
      check("rst_busy", busy, 0);
      check("rst_valid", result_valid, 0);
      check("rst_pass", pass, 0);
      check("rst_round", round, 0);
      tick();
      rst_n = 1'b1;
      new_frame = 1'b1;
      tick();

      foreach (vecs[i])
         run_round(vecs[i].player, vecs[i].col, vecs[i].exp_pass, vecs[i].exp_round, vecs[i].exp_depth);

      // Streak counter saturates at 15.
      for (int i = 0; i < 16; i++)
         run_round(8'd50, 1'b0, 1'b1, (i + 1 > 15) ? 4'd15 : 4'(i + 1), 8'd50);

      // Asynchronous reset while the wall is moving.
      player_depth = 8'd60;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (wall_depth !== 8'd30 && n < 1000) begin
         tick();
         n++;
      end
      check("reached_30", wall_depth, 30);
      #2 rst_n = 1'b0;
      #1;
      check("arst_depth", wall_depth, 0);
      check("arst_active", wall_active, 0);
      check("arst_busy", busy, 0);
      check("arst_valid", result_valid, 0);
      check("arst_pass", pass, 0);
      check("arst_round", round, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("arst_no_pulse", result_valid, 0);
      end
      rst_n = 1'b1;
      cur_round = 0;
      tick();
      check("post_rst_busy", busy, 0);
      run_round(8'd60, 1'b0, 1'b1, 4'd1, 8'd60);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
